// File: rtl/spike_window_decoder.sv
// Spike-count readout: counts output-neuron spikes and tracks peak membrane
// state over a programmable window, then reports with a one-cycle strobe.
module spike_window_decoder #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ST_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             spike_in,
    input  logic [ST_W-1:0]  state_in,
    input  logic [7:0]       window_len,
    input  logic [CNT_W-1:0] threshold,
    output logic [CNT_W-1:0] count_out,
    output logic [ST_W-1:0]  peak_out,
    output logic             hit,
    output logic             sat,
    output logic             valid,
    output logic             busy
);
    localparam int unsigned REM_W = 9;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [ST_W-1:0]    pk_q, pk_d;
    logic               sat_acc_q, sat_acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ST_W-1:0]    peak_q, peak_d;
    logic               hit_q, hit_d;
    logic               sat_q, sat_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic [CNT_W-1:0]   acc_next;
    logic [ST_W-1:0]    pk_next;
    logic               sat_next;
    logic [REM_W-1:0]   load_rem;

    // Next-state, accumulator and result computation.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        pk_d      = pk_q;
        sat_acc_d = sat_acc_q;
        count_d   = count_q;
        peak_d    = peak_q;
        hit_d     = hit_q;
        sat_d     = sat_q;

        acc_next = (spike_in && (acc_q != CNT_MAX)) ? acc_q + CNT_W'(1) : acc_q;
        sat_next = sat_acc_q | (spike_in & (acc_q == CNT_MAX));
        pk_next  = (state_in > pk_q) ? state_in : pk_q;
        load_rem = (window_len == 8'd0) ? REM_W'(256) : {1'b0, window_len};

        case (state_q)
            IDLE, REPORT: begin
                if (ena) begin
                    rem_d     = load_rem;
                    acc_d     = '0;
                    pk_d      = '0;
                    sat_acc_d = 1'b0;
                    state_d   = COUNT;
                end else begin
                    state_d = IDLE;
                end
            end
            COUNT: begin
                if (!ena) begin
                    state_d = IDLE;
                end else begin
                    acc_d     = acc_next;
                    pk_d      = pk_next;
                    sat_acc_d = sat_next;
                    rem_d     = rem_q - REM_W'(1);
                    // Last sample is folded directly into the published result.
                    if (rem_q == REM_W'(1)) begin
                        count_d = acc_next;
                        peak_d  = pk_next;
                        sat_d   = sat_next;
                        hit_d   = (acc_next >= threshold);
                        state_d = REPORT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == REPORT);
        busy_d  = (state_d == COUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            acc_q     <= '0;
            pk_q      <= '0;
            sat_acc_q <= 1'b0;
            count_q   <= '0;
            peak_q    <= '0;
            hit_q     <= 1'b0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            pk_q      <= pk_d;
            sat_acc_q <= sat_acc_d;
            count_q   <= count_d;
            peak_q    <= peak_d;
            hit_q     <= hit_d;
            sat_q     <= sat_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign count_out = count_q;
    assign peak_out  = peak_q;
    assign hit       = hit_q;
    assign sat       = sat_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
endmodule

// File: doc/spike_window_decoder.md
Name: spike_window_decoder

Overview:
- Downstream readout stage for the LIF network. Consumes the output neuron's spike line and membrane state.
- Counts spikes over a programmable window of clock cycles and records the peak membrane value seen in that window.
- At the end of each window it reports the count, the peak, a threshold-hit classification and a one-cycle valid strobe.
- Windows run back-to-back while enabled, with one report cycle between consecutive windows.

Parameters:
- CNT_W, 8, width of the spike counter, count_out and threshold.
- ST_W, 8, width of the membrane state input and peak_out.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- ena  input  1  run enable; windows run only while high.
- spike_in  input  1  spike line from the output neuron (bit 0 of its spike bus).
- state_in  input  ST_W  membrane state of the output neuron, unsigned.
- window_len  input  8  window length in cycles; 0 means 256.
- threshold  input  CNT_W  classification threshold, unsigned.
- count_out  output  CNT_W  spike count of the last completed window.
- peak_out  output  ST_W  maximum state_in of the last completed window.
- hit  output  1  count_out >= threshold, evaluated at window end.
- sat  output  1  count saturated during the last completed window.
- valid  output  1  one-cycle strobe: new result present.
- busy  output  1  high while in COUNT.

Behaviour:
- Reset:
  - Synchronous, active-high; rst is sampled on posedge clk and overrides everything.
  - Reset values: state=IDLE; count_out=0, peak_out=0, hit=0, sat=0, valid=0, busy=0; internal accumulators and remaining counter = 0.
- States: IDLE, COUNT, REPORT (2-bit encoding). busy = (state==COUNT).
- IDLE:
  - If ena=1, load rem <= (window_len==0 ? 256 : window_len) (9-bit), clear acc, pk and sat_acc, then go to COUNT.
  - Otherwise stay in IDLE.
- COUNT, one sample per cycle:
  - acc <= sat_add(acc, spike_in): increment only if spike_in=1 and acc < 2^CNT_W-1. An increment attempted at max sets sat_acc.
  - pk <= max(pk, state_in), unsigned compare.
  - rem <= rem-1.
- COUNT, last sample (rem==1), same edge:
  - count_out <= sat_add(acc, spike_in).
  - peak_out <= max(pk, state_in).
  - sat <= sat_acc OR (acc==max AND spike_in).
  - hit <= (final count >= threshold).
  - Go to REPORT.
  - Exactly N samples are taken per window; the last sample is included in the result.
- COUNT, abort: if ena=0 in any cycle, go to IDLE with no sample taken that cycle and no valid. Outputs keep the previous result; accumulators are cleared on the next load.
- REPORT:
  - valid=1 for exactly this cycle.
  - spike_in and state_in are ignored (dead cycle).
  - If ena=1, reload rem from window_len, clear accumulators and go to COUNT. Otherwise go to IDLE.
- Sampling of inputs:
  - window_len is sampled only at load (IDLE->COUNT or REPORT->COUNT); changes mid-window have no effect.
  - threshold is sampled only on the last-sample edge.
- Latency and period:
  - From the first rising edge with ena=1 in IDLE, valid rises N+1 edges later.
  - Continuous period is N+1 cycles.
- Outputs:
  - All outputs are registered; no combinational path from inputs to outputs.
  - count_out, peak_out, hit and sat hold until the next REPORT.
- Simultaneous events: rst and ena both high -> reset wins.
- Reset mid-COUNT or in REPORT: the window is discarded and all outputs return to 0 on that edge.

Test Plan:
- Reset: assert rst 2 cycles with ena=1 and spike_in=1 -> all outputs 0, busy=0. Release rst -> busy=1 after 1 edge.
- Basic window: window_len=10, threshold=5, spike_in=1 on 4 of the 10 sample cycles, state_in = 3,7,2 then 0 -> valid for one cycle 11 edges after start, count_out=4, peak_out=7, hit=0, sat=0. Next window with 5 spikes -> count_out=5, hit=1, valid 11 cycles after the previous valid.
- Wrap/saturation: window_len=0, spike_in held at 1 -> 256 samples, count_out=255, sat=1, valid 257 edges after start.
- Back-to-back with a mid-window length change: window_len=3, spike_in=1 constant, set window_len=6 during the first window -> first result 3, second result 6. Spike_in pulses during REPORT cycles are not counted.
- Abort: window_len=20, drop ena after 8 samples -> no valid, busy=0, previous count_out and peak_out retained. Re-raise ena -> fresh window starts from count 0.
- Reset mid-operation: rst for 1 cycle at sample 5 of 10 with ena=1 -> outputs 0 and no valid. The window restarts after reset; valid appears 11 edges after rst deassertion.
